// File: rtl/locked_adder_error_monitor.sv
// Error monitor for the XOR-locked ripple-carry adder.
// Recomputes the golden sum of each accepted operand pair and accumulates
// mismatch count, total Hamming distance and sticky per-bit error flags
// over a programmed vector window.
module locked_adder_error_monitor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 40
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   num_vectors_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   add1_i,
  input  logic [WIDTH-1:0]   add2_i,
  input  logic [WIDTH:0]     result_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   vec_count_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [ACC_W-1:0]   hd_sum_o,
  output logic [WIDTH:0]     bit_err_o
);

  localparam int unsigned RW = WIDTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ACC_W-1:0] hd_sum_q, hd_sum_d;
  logic [RW-1:0]    bit_err_q, bit_err_d;
  logic [RW-1:0]    diff_q, diff_d;
  logic             s1_v_q, s1_v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_c;
  logic [RW-1:0]    golden_c;
  logic [ACC_W:0]   hd_ext_c;

  function automatic logic [ACC_W-1:0] popcount(input logic [RW-1:0] v);
    logic [ACC_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < RW; i++) begin
      cnt = cnt + ACC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Handshake depends only on registered state, never on valid_i
  assign ready_o  = (state_q == ST_RUN) && (vec_count_q < target_q);
  // A vector arriving together with start_i belongs to the old window and is dropped
  assign accept_c = valid_i && ready_o && !start_i;
  assign golden_c = RW'(add1_i) + RW'(add2_i);
  assign hd_ext_c = {1'b0, hd_sum_q} + {1'b0, popcount(diff_q)};

  // Next-state logic for the window FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (start_i) begin
          state_d = ST_RUN;
        end else if ((vec_count_q == target_q) && !s1_v_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (start_i) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Two-stage datapath: capture the difference, then fold it into the statistics
  always_comb begin
    target_d    = target_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    hd_sum_d    = hd_sum_q;
    bit_err_d   = bit_err_q;
    diff_d      = diff_q;
    s1_v_d      = accept_c;
    busy_d      = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);

    if (accept_c) begin
      diff_d      = result_i ^ golden_c;
      vec_count_d = (vec_count_q == '1) ? vec_count_q : vec_count_q + CNT_W'(1);
    end

    if (s1_v_q) begin
      if (diff_q != '0) begin
        err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CNT_W'(1);
      end
      hd_sum_d  = hd_ext_c[ACC_W] ? '1 : hd_ext_c[ACC_W-1:0];
      bit_err_d = bit_err_q | diff_q;
    end

    if (start_i) begin
      target_d    = num_vectors_i;
      vec_count_d = '0;
      err_count_d = '0;
      hd_sum_d    = '0;
      bit_err_d   = '0;
      s1_v_d      = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      hd_sum_q    <= '0;
      bit_err_q   <= '0;
      diff_q      <= '0;
      s1_v_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      hd_sum_q    <= hd_sum_d;
      bit_err_q   <= bit_err_d;
      diff_q      <= diff_d;
      s1_v_q      <= s1_v_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign vec_count_o = vec_count_q;
  assign err_count_o = err_count_q;
  assign hd_sum_o    = hd_sum_q;
  assign bit_err_o   = bit_err_q;

endmodule

// File: tb/tb_locked_adder_error_monitor.sv
// Self-checking bench for locked_adder_error_monitor: a scoreboard queues the
// expected difference of every accepted vector and retires it when the
// statistics are due, alongside directed window/latency checks.
module tb_locked_adder_error_monitor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] num_vectors_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] add1_i;
  logic [15:0] add2_i;
  logic [16:0] result_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] vec_count_o;
  logic [31:0] err_count_o;
  logic [39:0] hd_sum_o;
  logic [16:0] bit_err_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [16:0] diff;
    int          due;
  } sb_t;

  sb_t         sb_q[$];
  int          exp_vec = 0;
  int          exp_err = 0;
  longint      exp_hd  = 0;
  logic [16:0] exp_bit = '0;

  locked_adder_error_monitor dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .num_vectors_i (num_vectors_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .add1_i        (add1_i),
    .add2_i        (add2_i),
    .result_i      (result_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .vec_count_o   (vec_count_o),
    .err_count_o   (err_count_o),
    .hd_sum_o      (hd_sum_o),
    .bit_err_o     (bit_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on acceptance, retire two edges later and compare statistics
  always @(negedge clk_i) begin
    sb_t e;
    bit  popped;
    popped = 1'b0;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.diff != 17'h0) exp_err++;
      exp_hd  += longint'($countones(e.diff));
      exp_bit |= e.diff;
      popped = 1'b1;
    end
    if (popped) begin
      check_val("sb_err", 64'(err_count_o), 64'(exp_err));
      check_val("sb_hd",  64'(hd_sum_o),    64'(exp_hd));
      check_val("sb_bit", 64'(bit_err_o),   64'(exp_bit));
    end
    if (rst_i || start_i) begin
      sb_q.delete();
      exp_vec = 0;
      exp_err = 0;
      exp_hd  = 0;
      exp_bit = '0;
    end else if (valid_i && ready_o) begin
      e.diff = result_i ^ ({1'b0, add1_i} + {1'b0, add2_i});
      e.due  = cyc + 2;
      sb_q.push_back(e);
      exp_vec++;
    end
  end

  task automatic align();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_win(input logic [31:0] n);
    align();
    start_i       = 1'b1;
    num_vectors_i = n;
    align();
    start_i       = 1'b0;
  endtask

  // Present one vector and hold it until accepted; returns 1 time unit after the accept edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
    int n;
    n        = 0;
    valid_i  = 1'b1;
    add1_i   = a;
    add2_i   = b;
    result_i = r;
    @(negedge clk_i);
    while (!ready_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    if (!ready_o) check_val("send_ready", 64'(ready_o), 64'd1);
    align();
    valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk_i);
    while (!done_o && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    check_val("wait_done", 64'(done_o), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_ready"}, 64'(ready_o),     64'd0);
    check_val({tag, "_busy"},  64'(busy_o),      64'd0);
    check_val({tag, "_done"},  64'(done_o),      64'd0);
    check_val({tag, "_vec"},   64'(vec_count_o), 64'd0);
    check_val({tag, "_err"},   64'(err_count_o), 64'd0);
    check_val({tag, "_hd"},    64'(hd_sum_o),    64'd0);
    check_val({tag, "_bit"},   64'(bit_err_o),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  pat;
    logic [15:0] a, b;
    rst_i = 1'b1; start_i = 1'b0; num_vectors_i = '0; valid_i = 1'b0;
    add1_i = '0; add2_i = '0; result_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_idle("reset");

    // Correct key: every result matches the golden sum
    start_win(32'd4);
    @(negedge clk_i);
    check_val("ck_busy",  64'(busy_o),  64'd1);
    check_val("ck_ready", 64'(ready_o), 64'd1);
    check_val("ck_done0", 64'(done_o),  64'd0);
    align();
    send(16'h0001, 16'h0001, 17'h00002);
    send(16'hFFFF, 16'h0001, 17'h10000);
    send(16'h1234, 16'h4321, 17'h05555);
    send(16'h0000, 16'h0000, 17'h00000);
    wait_done();
    check_val("ck_vec",  64'(vec_count_o), 64'd4);
    check_val("ck_err",  64'(err_count_o), 64'd0);
    check_val("ck_hd",   64'(hd_sum_o),    64'd0);
    check_val("ck_bit",  64'(bit_err_o),   64'd0);
    check_val("ck_busy_done", 64'(busy_o), 64'd0);

    // Single-bit corruption in the carry-out bit, with done latency
    start_win(32'd1);
    send(16'hFFFF, 16'h0001, 17'h00000);
    @(negedge clk_i);
    check_val("sb1_vec",   64'(vec_count_o), 64'd1);
    check_val("sb1_done_a", 64'(done_o), 64'd0);
    @(negedge clk_i);
    check_val("sb1_done_b", 64'(done_o), 64'd0);
    check_val("sb1_ready",  64'(ready_o), 64'd0);
    @(negedge clk_i);
    check_val("sb1_done_c", 64'(done_o), 64'd1);
    check_val("sb1_err", 64'(err_count_o), 64'd1);
    check_val("sb1_hd",  64'(hd_sum_o),    64'd1);
    check_val("sb1_bit", 64'(bit_err_o),   64'h10000);

    // Multi-bit errors and sticky flags: 0xFF (8 bits) then 0x100 (1 bit)
    start_win(32'd2);
    send(16'h0000, 16'h0000, 17'h000FF);
    send(16'h0001, 16'h0000, 17'h00101);
    wait_done();
    check_val("mb_err", 64'(err_count_o), 64'd2);
    check_val("mb_hd",  64'(hd_sum_o),    64'd9);
    check_val("mb_bit", 64'(bit_err_o),   64'h001FF);

    // Window boundary with a 2-cycle valid gap: six valid cycles, three accepts
    start_win(32'd3);
    pat = 8'b1111_0011;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      valid_i  = pat[i];
      add1_i   = a;
      add2_i   = b;
      result_i = {1'b0, a} + {1'b0, b};
      align();
    end
    valid_i = 1'b0;
    @(negedge clk_i);
    check_val("win_vec",   64'(vec_count_o), 64'd3);
    check_val("win_ready", 64'(ready_o),     64'd0);
    check_val("win_sbvec", 64'(exp_vec),     64'd3);
    wait_done();
    check_val("win_err", 64'(err_count_o), 64'd0);

    // Empty window: one RUN cycle, then DONE
    start_win(32'd0);
    @(negedge clk_i);
    check_val("z_busy",  64'(busy_o),  64'd1);
    check_val("z_ready", 64'(ready_o), 64'd0);
    check_val("z_done0", 64'(done_o),  64'd0);
    @(negedge clk_i);
    check_val("z_busy1", 64'(busy_o),  64'd0);
    check_val("z_done1", 64'(done_o),  64'd1);
    check_val("z_vec",   64'(vec_count_o), 64'd0);
    check_val("z_err",   64'(err_count_o), 64'd0);

    // Reset mid-window discards everything
    start_win(32'd5);
    send(16'h0010, 16'h0020, 17'h00031);
    send(16'h0100, 16'h0001, 17'h00000);
    rst_i = 1'b1;
    align();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle("midrst");

    // Restart mid-window: the vector presented with start_i is dropped
    start_win(32'd5);
    send(16'h0001, 16'h0001, 17'h00003);
    start_i       = 1'b1;
    num_vectors_i = 32'd1;
    valid_i       = 1'b1;
    add1_i        = 16'h00FF;
    add2_i        = 16'h0001;
    result_i      = 17'h00000;
    align();
    start_i = 1'b0;
    @(negedge clk_i);
    check_val("rs_vec0", 64'(vec_count_o), 64'd0);
    check_val("rs_err0", 64'(err_count_o), 64'd0);
    check_val("rs_busy", 64'(busy_o),      64'd1);
    align();
    valid_i = 1'b0;
    wait_done();
    check_val("rs_vec", 64'(vec_count_o), 64'd1);
    check_val("rs_err", 64'(err_count_o), 64'd1);
    check_val("rs_hd",  64'(hd_sum_o),    64'd1);
    check_val("rs_bit", 64'(bit_err_o),   64'h00100);

    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
